// File: rtl/led_blinker.sv
// Purpose: LED square-wave blinker; two async switches pick one of four fixed blink rates.
// Latency: toggle edge to o_led 1 clock; switch change to new source on o_led 3 clocks.
// Backpressure: none; all generators free-run every clock and the output is always valid.
module led_blinker #(
    parameter int HALF_0 = 125000,
    parameter int HALF_1 = 250000,
    parameter int HALF_2 = 1250000,
    parameter int HALF_3 = 12500000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_switch_1,
    input  logic i_switch_2,
    output logic o_led
);

    // Half-period lookup by generator index, used to elaborate the four generators.
    function automatic int half_of(input int n);
        case (n)
            0:       half_of = HALF_0;
            1:       half_of = HALF_1;
            2:       half_of = HALF_2;
            default: half_of = HALF_3;
        endcase
    endfunction

    localparam int HALF_MAX_01 = (HALF_0 > HALF_1) ? HALF_0 : HALF_1;
    localparam int HALF_MAX_23 = (HALF_2 > HALF_3) ? HALF_2 : HALF_3;
    localparam int HALF_MAX    = (HALF_MAX_01 > HALF_MAX_23) ? HALF_MAX_01 : HALF_MAX_23;
    // A counter only ever holds 0..HALF-1, so clog2(HALF) bits suffice; keep at least one bit.
    localparam int CNT_W       = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

    logic [3:0] toggle;
    logic [1:0] sync_stage1;
    logic [1:0] sync_stage2;
    logic [1:0] sel;

    // Four independent toggle generators. They never pause or restart on a rate change,
    // so switching rates picks up the target generator at whatever phase it is in.
    for (genvar g = 0; g < 4; g++) begin : gen_rate
        localparam int              HALF = half_of(g);
        localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

        logic [CNT_W-1:0] count;
        logic             tog;

        // Count 0..HALF-1, flipping the toggle on the wrap so each phase lasts HALF clocks.
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                count <= '0;
                tog   <= 1'b0;
            end else if (count == LAST) begin
                count <= '0;
                tog   <= ~tog;
            end else begin
                count <= count + 1'b1;
            end
        end

        assign toggle[g] = tog;
    end

    // Two-flop synchronizer on both switches; no debounce, the LED simply follows bounces.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_stage1 <= 2'b00;
            sync_stage2 <= 2'b00;
        end else begin
            sync_stage1 <= {i_switch_1, i_switch_2};
            sync_stage2 <= sync_stage1;
        end
    end

    assign sel = sync_stage2;

    // Registered 4:1 select keeps the pin glitch-free apart from a single cycle at a rate change.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_led <= 1'b0;
        end else begin
            o_led <= toggle[sel];
        end
    end

endmodule

// File: tb/tb_led_blinker.sv
module tb_led_blinker;

    localparam int MAXC = 4096;

    logic i_clk;
    logic i_reset;
    logic i_switch_1;
    logic i_switch_2;
    logic o_led;

    led_blinker #(
        .HALF_0(2),
        .HALF_1(4),
        .HALF_2(6),
        .HALF_3(8)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_switch_1(i_switch_1),
        .i_switch_2(i_switch_2),
        .o_led     (o_led)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int t     = 0;          // number of rising edges applied so far

    bit         rst_h   [MAXC];
    logic [1:0] sw_h    [MAXC];
    int         since_h [MAXC];   // edges since the most recent reset edge
    logic       led_h   [MAXC];   // observed o_led after each edge

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic int half_tb(input int n);
        case (n)
            0:       half_tb = 2;
            1:       half_tb = 4;
            2:       half_tb = 6;
            default: half_tb = 8;
        endcase
    endfunction

    // Reference: a generator's level after edge e is floor(edges_since_reset / HALF) mod 2.
    function automatic logic tog_m(input int n, input int e);
        if (e < 0 || rst_h[e]) return 1'b0;
        return ((since_h[e] / half_tb(n)) % 2) == 1;
    endfunction

    // Switch value seen by the select two edges after it was presented.
    function automatic logic [1:0] sel_m(input int e);
        if (e < 0 || rst_h[e]) return 2'b00;
        if (e - 1 < 0 || rst_h[e-1]) return 2'b00;
        return sw_h[e-1];
    endfunction

    function automatic logic led_m(input int e);
        if (e < 0 || rst_h[e]) return 1'b0;
        return tog_m(int'(sel_m(e-1)), e-1);
    endfunction

    task automatic step(input bit r, input logic [1:0] s);
        i_reset    = r;
        i_switch_1 = s[1];
        i_switch_2 = s[0];
        @(posedge i_clk);
        rst_h[t]   = r;
        sw_h[t]    = s;
        since_h[t] = (r || t == 0) ? 0 : since_h[t-1] + 1;
        #1;
        led_h[t] = o_led;
        chk("led_vs_model", {31'b0, o_led}, {31'b0, led_m(t)});
        t++;
    endtask

    // Over the last two periods of a steady rate: exactly 2H high clocks, two rises 2H apart.
    task automatic check_window(input string tag, input int h);
        int highs;
        int rises;
        int first_r;
        int last_r;
        highs = 0; rises = 0; first_r = -1; last_r = -1;
        for (int e = t - 4*h; e < t; e++) begin
            if (led_h[e] === 1'b1) highs++;
            if (led_h[e] === 1'b1 && led_h[e-1] === 1'b0) begin
                rises++;
                if (first_r < 0) first_r = e;
                last_r = e;
            end
        end
        chk({tag, "_high"}, highs, 2*h);
        chk({tag, "_rises"}, rises, 2);
        chk({tag, "_period"}, last_r - first_r, 2*h);
    endtask

    initial begin
        int r_edge;
        int first_rise;
        int sw_edge;
        int found;
        int rise_at;

        i_reset = 1'b1; i_switch_1 = 1'b0; i_switch_2 = 1'b0;

        // Reset held 3 clocks with arbitrary switches.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)));
            chk("reset_low", {31'b0, o_led}, 32'd0);
        end
        r_edge = t - 1;

        // Select 00: first rise 3 clocks after release, then period 4.
        first_rise = -1;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 2'b00);
            if (i == 0) chk("first_after_release", {31'b0, o_led}, 32'd0);
            if (first_rise < 0 && led_h[t-1] === 1'b1) first_rise = t - 1;
        end
        chk("first_rise_00", first_rise - r_edge, 3);
        check_window("sel00", 2);

        // Sweep 01, 10, 11 for 40 clocks each.
        for (int s = 1; s < 4; s++) begin
            for (int i = 0; i < 40; i++) step(1'b0, 2'(s));
            check_window($sformatf("sel%0d", s), half_tb(s));
        end

        // Switch 00 -> 11 mid-run: new source appears on the third edge, phase not restarted.
        for (int i = 0; i < 21; i++) step(1'b0, 2'b00);
        sw_edge = t;
        for (int i = 0; i < 20; i++) step(1'b0, 2'b11);
        chk("switch_track_3clk", {31'b0, led_h[sw_edge+2]},
            {31'b0, 1'((since_h[sw_edge+1] / 8) % 2)});
        chk("switch_not_yet", {31'b0, led_h[sw_edge+1]},
            {31'b0, 1'((since_h[sw_edge] / 2) % 2)});

        // One-clock reset while LED is high under select 11.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step(1'b0, 2'b11);
            if (led_h[t-1] === 1'b1) found = 1;
        end
        chk("led_high_before_reset", found, 1);
        step(1'b1, 2'b11);
        chk("reset_clears_led", {31'b0, o_led}, 32'd0);
        rise_at = -1;
        for (int i = 1; i <= 20 && rise_at < 0; i++) begin
            step(1'b0, 2'b11);
            if (led_h[t-1] === 1'b1) rise_at = i;
        end
        chk("rise_after_reset", rise_at, 9);

        // Rapid switch changes every clock.
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 2'(i % 4));
            chk("led_known", {31'b0, $isunknown(o_led)}, 32'd0);
        end

        // Random switches with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
